// File: rtl/id_ex_stage_reg_pkg.sv
// rtl/id_ex_stage_reg_pkg.sv - shared ID/EX payload type, widths and control bit indices
package id_ex_stage_reg_pkg;

   localparam int ID_EX_DATA_W     = 32;
   localparam int ID_EX_REG_ADDR_W = 5;
   localparam int ID_EX_CTRL_W     = 8;

   localparam int CTRL_REGWRITE = 0;

   typedef struct packed {
      logic [ID_EX_DATA_W-1:0]     rd1;
      logic [ID_EX_DATA_W-1:0]     rd2;
      logic [ID_EX_DATA_W-1:0]     imm_ext;
      logic [ID_EX_REG_ADDR_W-1:0] rt;
      logic [ID_EX_REG_ADDR_W-1:0] rd;
      logic [ID_EX_CTRL_W-1:0]     ctrl;
   } id_ex_payload_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// rtl/pipe_skid_buf.sv - two-entry valid/ready skid buffer with flush, registered in_ready
module pipe_skid_buf #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic         m_valid, m_valid_nxt;
   logic         s_valid, s_valid_nxt;
   logic [W-1:0] m_data, m_data_nxt;
   logic [W-1:0] s_data, s_data_nxt;
   logic         rdy_q;
   logic         accept, retire;

   assign in_ready = rdy_q && !rst;
   assign accept   = in_valid && in_ready;
   assign retire   = m_valid && out_ready;

   // Empty entries always hold zero, so the outputs never show stale data.
   always_comb begin
      m_valid_nxt = m_valid;
      m_data_nxt  = m_data;
      s_valid_nxt = s_valid;
      s_data_nxt  = s_data;
      if (flush) begin
         m_valid_nxt = 1'b0;
         m_data_nxt  = '0;
         s_valid_nxt = 1'b0;
         s_data_nxt  = '0;
      end else if (s_valid) begin
         if (retire) begin
            m_data_nxt  = s_data;
            s_valid_nxt = 1'b0;
            s_data_nxt  = '0;
         end
      end else if (!m_valid || retire) begin
         m_valid_nxt = accept;
         m_data_nxt  = accept ? in_data : '0;
      end else if (accept) begin
         s_valid_nxt = 1'b1;
         s_data_nxt  = in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         m_valid <= 1'b0;
         m_data  <= '0;
         s_valid <= 1'b0;
         s_data  <= '0;
         rdy_q   <= 1'b1;
      end else begin
         m_valid <= m_valid_nxt;
         m_data  <= m_data_nxt;
         s_valid <= s_valid_nxt;
         s_data  <= s_data_nxt;
         rdy_q   <= !s_valid_nxt;
      end
   end

   assign out_valid = m_valid;
   assign out_data  = m_data;

   a_stall_stable: assert property (@(posedge clk) disable iff (rst)
      (m_valid && !out_ready && !flush) |=> (m_valid && $stable(m_data)));
   a_occupancy: assert property (@(posedge clk) disable iff (rst) s_valid |-> m_valid);
   a_flush_empty: assert property (@(posedge clk) disable iff (rst)
      flush |=> (!m_valid && !s_valid));

endmodule

// File: rtl/id_ex_stage_reg.sv
// rtl/id_ex_stage_reg.sv - ID->EX pipeline register, optional skid entry, flush to NOP bubble
module id_ex_stage_reg
   import id_ex_stage_reg_pkg::*;
#(
   parameter int DATA_W     = ID_EX_DATA_W,
   parameter int REG_ADDR_W = ID_EX_REG_ADDR_W,
   parameter int CTRL_W     = ID_EX_CTRL_W,
   parameter int SKID       = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_W-1:0]     RD1_in,
   input  logic [DATA_W-1:0]     RD2_in,
   input  logic [DATA_W-1:0]     imm_ext_in,
   input  logic [REG_ADDR_W-1:0] rt_in,
   input  logic [REG_ADDR_W-1:0] rd_in,
   input  logic [CTRL_W-1:0]     ctrl_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_W-1:0]     RD1_out,
   output logic [DATA_W-1:0]     RD2_out,
   output logic [DATA_W-1:0]     imm_ext_out,
   output logic [REG_ADDR_W-1:0] rt_out,
   output logic [REG_ADDR_W-1:0] rd_out,
   output logic [CTRL_W-1:0]     ctrl_out
);

   typedef struct packed {
      logic [DATA_W-1:0]     rd1;
      logic [DATA_W-1:0]     rd2;
      logic [DATA_W-1:0]     imm_ext;
      logic [REG_ADDR_W-1:0] rt;
      logic [REG_ADDR_W-1:0] rd;
      logic [CTRL_W-1:0]     ctrl;
   } payload_t;

   payload_t in_p, out_p;

   assign in_p = '{rd1: RD1_in, rd2: RD2_in, imm_ext: imm_ext_in,
                   rt: rt_in, rd: rd_in, ctrl: ctrl_in};

   generate
      if (SKID != 0) begin : g_skid
         pipe_skid_buf #(.W($bits(payload_t))) u_buf (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .in_data   (in_p),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .out_data  (out_p)
         );
      end else begin : g_single
         // Single entry: a retiring beat frees the slot in the same cycle.
         logic     m_valid;
         payload_t m_data;

         assign in_ready = (!m_valid || out_ready) && !rst;

         always_ff @(posedge clk) begin
            if (rst || flush) begin
               m_valid <= 1'b0;
               m_data  <= '0;
            end else if (in_valid && in_ready) begin
               m_valid <= 1'b1;
               m_data  <= in_p;
            end else if (m_valid && out_ready) begin
               m_valid <= 1'b0;
               m_data  <= '0;
            end
         end

         assign out_valid = m_valid;
         assign out_p     = m_data;
      end
   endgenerate

   assign RD1_out     = out_p.rd1;
   assign RD2_out     = out_p.rd2;
   assign imm_ext_out = out_p.imm_ext;
   assign rt_out      = out_p.rt;
   assign rd_out      = out_p.rd;
   assign ctrl_out    = out_p.ctrl;

   a_bubble_nop: assert property (@(posedge clk) disable iff (rst)
      !out_valid |-> (out_p == '0 && ctrl_out[CTRL_REGWRITE] == 1'b0));

endmodule
